// File: rtl/sssp_level_sequencer.sv
// ---------------------------------------------------------------------------
// sssp_level_sequencer
//
// Purpose:
//   Drives one or more sssp_pipeline instances through BFS/SSSP levels.
//   A run first streams the vertex state into the pipeline BRAMs
//   (pipe_control=1). It then replays the edge stream once per level
//   (pipe_control=2) and counts the updates each level produces. After each
//   level it either advances current_level or stops. It stops on
//   convergence (no updates), on reaching cfg_max_level, or when the
//   pipeline fails to drain in time.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             pulse that begins a run (ignored while busy)
//   cfg_load_words    vertex words to load (sampled at start)
//   cfg_edge_words    edge words per level (sampled at start)
//   cfg_max_level     last level to process (sampled at start)
//   src_valid         upstream word valid
//   src_ready         sequencer accepts a word this cycle
//   level_start       one-cycle pulse: upstream must rewind the edge stream
//   pipe_control      0 idle, 1 load, 2 scatter
//   pipe_word_valid   accepted beat (src_valid & src_ready)
//   pipe_last_input   final accepted beat of a LOAD or SCATTER phase
//   current_level     level driven to the pipelines
//   pipe_valid_out    pipeline update strobe
//   pipe_last_out     pipeline has flushed the final beat
//   busy, done, error run status; done/error held until the next start
//   level_updates     updates counted in the current level (saturating)
// ---------------------------------------------------------------------------
module sssp_level_sequencer #(
    parameter int CNT_W         = 32,
    parameter int LEVEL_W       = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   cfg_load_words,
    input  logic [CNT_W-1:0]   cfg_edge_words,
    input  logic [LEVEL_W-1:0] cfg_max_level,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               level_start,
    output logic [1:0]         pipe_control,
    output logic               pipe_word_valid,
    output logic               pipe_last_input,
    output logic [LEVEL_W-1:0] current_level,
    input  logic               pipe_valid_out,
    input  logic               pipe_last_out,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   level_updates
);

    // One spare bit so the timer can reach DRAIN_TIMEOUT without wrapping.
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCATTER,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   load_words;
    logic [CNT_W-1:0]   edge_words;
    logic [LEVEL_W-1:0] max_level;
    logic [CNT_W-1:0]   word_cnt;
    logic [TMR_W-1:0]   drain_timer;
    logic [CNT_W-1:0]   phase_words;
    logic               accept;
    logic               last_beat;
    logic               count_update;

    // Handshake and phase decode. All of it follows from the registered
    // state, so the pipelines see a stable control value for each cycle.
    // DRAIN and NEXT keep control at 2 because the pipeline gates its
    // output stage on the live control value.
    always_comb begin
        phase_words     = (state == S_LOAD) ? load_words : edge_words;
        src_ready       = (state == S_LOAD) || (state == S_SCATTER);
        accept          = src_valid && src_ready;
        last_beat       = accept && (word_cnt == phase_words - CNT_W'(1));
        pipe_word_valid = accept;
        pipe_last_input = last_beat;
        busy            = (state != S_IDLE) && (state != S_DONE);
        count_update    = pipe_valid_out && ((state == S_SCATTER) || (state == S_DRAIN));
        case (state)
            S_LOAD:                       pipe_control = 2'd1;
            S_SCATTER, S_DRAIN, S_NEXT:   pipe_control = 2'd2;
            default:                      pipe_control = 2'd0;
        endcase
    end

    // Level sequencing FSM. level_start is set on every transition into
    // SCATTER, so it is high during the first SCATTER cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            load_words    <= '0;
            edge_words    <= '0;
            max_level     <= '0;
            word_cnt      <= '0;
            drain_timer   <= '0;
            current_level <= '0;
            level_updates <= '0;
            level_start   <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            level_start <= 1'b0;

            // The counter saturates rather than wrapping to zero, because a
            // wrap would look like convergence.
            if (count_update && (level_updates != '1)) begin
                level_updates <= level_updates + CNT_W'(1);
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        load_words    <= cfg_load_words;
                        edge_words    <= cfg_edge_words;
                        max_level     <= cfg_max_level;
                        current_level <= '0;
                        word_cnt      <= '0;
                        drain_timer   <= '0;
                        level_updates <= '0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        if (cfg_load_words != '0) begin
                            state <= S_LOAD;
                        end else if (cfg_edge_words != '0) begin
                            state       <= S_SCATTER;
                            level_start <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        if (last_beat) begin
                            word_cnt <= '0;
                            if (edge_words != '0) begin
                                state       <= S_SCATTER;
                                level_start <= 1'b1;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end

                S_SCATTER: begin
                    if (accept) begin
                        if (last_beat) begin
                            word_cnt    <= '0;
                            drain_timer <= '0;
                            state       <= S_DRAIN;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end

                // Wait for the final beat to leave the pipeline. Updates
                // that arrive in the same cycle as pipe_last_out are
                // counted above.
                S_DRAIN: begin
                    if (pipe_last_out) begin
                        state <= S_NEXT;
                    end else if (drain_timer == TMR_W'(DRAIN_TIMEOUT)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_timer <= drain_timer + TMR_W'(1);
                    end
                end

                // The max-level check runs before the increment, so
                // current_level never wraps.
                S_NEXT: begin
                    if ((level_updates == '0) || (current_level == max_level)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        current_level <= current_level + LEVEL_W'(1);
                        word_cnt      <= '0;
                        level_updates <= '0;
                        level_start   <= 1'b1;
                        state         <= S_SCATTER;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sssp_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sssp_level_sequencer
//
// Purpose:
//   Directed testbench for sssp_level_sequencer. A small behavioural
//   pipeline returns pipe_valid_out and pipe_last_out three stages after the
//   corresponding scatter beats. A negedge monitor accumulates event counts,
//   and each scenario task compares them with hand-computed values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sssp_level_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_load_words;
    logic [31:0] cfg_edge_words;
    logic [7:0]  cfg_max_level;
    logic        src_valid;
    logic        src_ready;
    logic        level_start;
    logic [1:0]  pipe_control;
    logic        pipe_word_valid;
    logic        pipe_last_input;
    logic [7:0]  current_level;
    logic        pipe_valid_out;
    logic        pipe_last_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] level_updates;

    int total = 0;
    int bad   = 0;

    // Pipeline model controls (written only by the test sequence).
    int   upd_levels = 0;
    int   upd_from   = 0;
    logic lo_enable  = 1'b1;

    sssp_level_sequencer #(
        .CNT_W         (32),
        .LEVEL_W       (8),
        .DRAIN_TIMEOUT (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_load_words  (cfg_load_words),
        .cfg_edge_words  (cfg_edge_words),
        .cfg_max_level   (cfg_max_level),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .level_start     (level_start),
        .pipe_control    (pipe_control),
        .pipe_word_valid (pipe_word_valid),
        .pipe_last_input (pipe_last_input),
        .current_level   (current_level),
        .pipe_valid_out  (pipe_valid_out),
        .pipe_last_out   (pipe_last_out),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .level_updates   (level_updates)
    );

    always #5 clk = ~clk;

    // Behavioural pipeline. A scatter beat whose index within the level is
    // at least upd_from (on levels below upd_levels) produces one update
    // three stages later. The last scatter beat returns as pipe_last_out.
    logic [2:0] lo_d;
    logic [2:0] vo_d;
    int         beat_idx;
    int         idx_now;

    always_comb idx_now = level_start ? 0 : beat_idx;

    always @(negedge clk) begin
        if (rst) begin
            lo_d     <= '0;
            vo_d     <= '0;
            beat_idx <= 0;
        end else begin
            lo_d <= {lo_d[1:0], pipe_last_input && (pipe_control == 2'd2)};
            vo_d <= {vo_d[1:0], pipe_word_valid && (pipe_control == 2'd2)
                                && (int'(current_level) < upd_levels) && (idx_now >= upd_from)};
            if (pipe_word_valid && (pipe_control == 2'd2)) beat_idx <= idx_now + 1;
            else if (level_start) beat_idx <= 0;
        end
    end

    assign pipe_last_out  = lo_d[2] && lo_enable;
    assign pipe_valid_out = vo_d[2];

    // Event monitor, sampled mid-cycle.
    int          n_load_beats  = 0;
    int          n_scat_beats  = 0;
    int          n_ctrl1_cyc   = 0;
    int          n_ctrl2_cyc   = 0;
    int          n_drain_cyc   = 0;
    int          n_level_start = 0;
    int          n_last_in     = 0;
    int          n_bad_last    = 0;
    int          n_bad_accept  = 0;
    logic [31:0] peak_upd      = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pipe_word_valid && (pipe_control == 2'd1)) n_load_beats++;
            if (pipe_word_valid && (pipe_control == 2'd2)) n_scat_beats++;
            if (pipe_control == 2'd1) n_ctrl1_cyc++;
            if (pipe_control == 2'd2) n_ctrl2_cyc++;
            if ((pipe_control == 2'd2) && !src_ready) n_drain_cyc++;
            if (level_start) n_level_start++;
            if (pipe_last_input) n_last_in++;
            if (pipe_last_input && !pipe_word_valid) n_bad_last++;
            if (pipe_word_valid && !src_valid) n_bad_accept++;
            if (start) peak_upd = '0;
            else if (level_updates > peak_upd) peak_upd = level_updates;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lw, input int ew, input int ml);
        cfg_load_words = lw;
        cfg_edge_words = ew;
        cfg_max_level  = 8'(ml);
        start          = 1'b1;
        step();
        start          = 1'b0;
    endtask

    // Feed words (one valid cycle out of every 'gap') until done or the budget expires.
    task automatic run_until_done(input int max_cyc, input int gap);
        int cyc;
        cyc = 0;
        while (!done && (cyc < max_cyc)) begin
            src_valid = (gap <= 1) ? 1'b1 : ((cyc % gap) == 0);
            step();
            cyc++;
        end
        src_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src_valid = 1'b1;
        cfg_load_words = 0; cfg_edge_words = 0; cfg_max_level = 0;
        repeat (3) step();
        total++; if (pipe_control !== 2'd0) begin bad++; $display("[TB] FAIL reset_control got=%0d want=0", pipe_control); end
        total++; if ({src_ready, pipe_word_valid, pipe_last_input, level_start} !== 4'b0) begin bad++; $display("[TB] FAIL reset_handshake got=%b want=0000", {src_ready, pipe_word_valid, pipe_last_input, level_start}); end
        total++; if ({busy, done, error} !== 3'b0) begin bad++; $display("[TB] FAIL reset_status got=%b want=000", {busy, done, error}); end
        total++; if ((current_level !== 8'd0) || (level_updates !== 32'd0)) begin bad++; $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", current_level, level_updates); end
        rst = 1'b0; src_valid = 1'b0;
        step();
    endtask

    task automatic test_full_run();
        int ld0, sc0, ls0, li0;
        upd_levels = 2; upd_from = 4; lo_enable = 1'b1;
        ld0 = n_load_beats; sc0 = n_scat_beats; ls0 = n_level_start; li0 = n_last_in;
        do_start(4, 6, 5);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL full_busy got=%0d want=1", busy); end
        run_until_done(400, 1);
        step();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL full_done got=%0d want=1", done); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL full_error got=%0d want=0", error); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full_idle got=%0d want=0", busy); end
        total++; if (current_level !== 8'd2) begin bad++; $display("[TB] FAIL full_level got=%0d want=2", current_level); end
        total++; if (level_updates !== 32'd0) begin bad++; $display("[TB] FAIL full_final_upd got=%0d want=0", level_updates); end
        total++; if (n_load_beats - ld0 !== 4) begin bad++; $display("[TB] FAIL full_load_beats got=%0d want=4", n_load_beats - ld0); end
        total++; if (n_scat_beats - sc0 !== 18) begin bad++; $display("[TB] FAIL full_scat_beats got=%0d want=18", n_scat_beats - sc0); end
        total++; if (n_level_start - ls0 !== 3) begin bad++; $display("[TB] FAIL full_level_starts got=%0d want=3", n_level_start - ls0); end
        total++; if (n_last_in - li0 !== 4) begin bad++; $display("[TB] FAIL full_last_inputs got=%0d want=4", n_last_in - li0); end
        total++; if (peak_upd !== 32'd2) begin bad++; $display("[TB] FAIL full_peak_upd got=%0d want=2", peak_upd); end
    endtask

    task automatic test_gapped();
        int ld0, sc0, li0, bl0, ba0;
        upd_levels = 1; upd_from = 0;
        ld0 = n_load_beats; sc0 = n_scat_beats; li0 = n_last_in; bl0 = n_bad_last; ba0 = n_bad_accept;
        do_start(3, 4, 0);
        run_until_done(400, 3);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL gap_done got=%0d want=1", done); end
        total++; if (n_load_beats - ld0 !== 3) begin bad++; $display("[TB] FAIL gap_load_beats got=%0d want=3", n_load_beats - ld0); end
        total++; if (n_scat_beats - sc0 !== 4) begin bad++; $display("[TB] FAIL gap_scat_beats got=%0d want=4", n_scat_beats - sc0); end
        total++; if (n_last_in - li0 !== 2) begin bad++; $display("[TB] FAIL gap_last_inputs got=%0d want=2", n_last_in - li0); end
        total++; if (n_bad_last - bl0 !== 0) begin bad++; $display("[TB] FAIL gap_last_unaccepted got=%0d want=0", n_bad_last - bl0); end
        total++; if (n_bad_accept - ba0 !== 0) begin bad++; $display("[TB] FAIL gap_accept_no_valid got=%0d want=0", n_bad_accept - ba0); end
        total++; if (level_updates !== 32'd4) begin bad++; $display("[TB] FAIL gap_updates got=%0d want=4", level_updates); end
        total++; if (current_level !== 8'd0) begin bad++; $display("[TB] FAIL gap_level got=%0d want=0", current_level); end
    endtask

    task automatic test_max_level();
        int ls0, sc0;
        upd_levels = 100; upd_from = 0;
        ls0 = n_level_start; sc0 = n_scat_beats;
        do_start(2, 3, 2);
        run_until_done(400, 1);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL max_done got=%0d want=1", done); end
        total++; if (n_level_start - ls0 !== 3) begin bad++; $display("[TB] FAIL max_level_starts got=%0d want=3", n_level_start - ls0); end
        total++; if (current_level !== 8'd2) begin bad++; $display("[TB] FAIL max_level got=%0d want=2", current_level); end
        total++; if (level_updates !== 32'd3) begin bad++; $display("[TB] FAIL max_updates got=%0d want=3", level_updates); end
        total++; if (n_scat_beats - sc0 !== 9) begin bad++; $display("[TB] FAIL max_scat_beats got=%0d want=9", n_scat_beats - sc0); end
    endtask

    task automatic test_zero_words();
        int c10, c20, ls0, ld0, sc0, li0;
        upd_levels = 0; upd_from = 0;
        c10 = n_ctrl1_cyc; ls0 = n_level_start; sc0 = n_scat_beats;
        do_start(0, 3, 0);
        run_until_done(200, 1);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL zload_done got=%0d want=1", done); end
        total++; if (n_ctrl1_cyc - c10 !== 0) begin bad++; $display("[TB] FAIL zload_ctrl1 got=%0d want=0", n_ctrl1_cyc - c10); end
        total++; if (n_level_start - ls0 !== 1) begin bad++; $display("[TB] FAIL zload_level_starts got=%0d want=1", n_level_start - ls0); end
        total++; if (n_scat_beats - sc0 !== 3) begin bad++; $display("[TB] FAIL zload_scat_beats got=%0d want=3", n_scat_beats - sc0); end
        c20 = n_ctrl2_cyc; ls0 = n_level_start; ld0 = n_load_beats; li0 = n_last_in;
        do_start(2, 0, 0);
        run_until_done(200, 1);
        step();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL zedge_done got=%0d want=1", done); end
        total++; if (n_level_start - ls0 !== 0) begin bad++; $display("[TB] FAIL zedge_level_starts got=%0d want=0", n_level_start - ls0); end
        total++; if (n_ctrl2_cyc - c20 !== 0) begin bad++; $display("[TB] FAIL zedge_ctrl2 got=%0d want=0", n_ctrl2_cyc - c20); end
        total++; if (n_load_beats - ld0 !== 2) begin bad++; $display("[TB] FAIL zedge_load_beats got=%0d want=2", n_load_beats - ld0); end
        total++; if (n_last_in - li0 !== 1) begin bad++; $display("[TB] FAIL zedge_last_inputs got=%0d want=1", n_last_in - li0); end
    endtask

    task automatic test_timeout();
        int dr0;
        upd_levels = 0; upd_from = 0; lo_enable = 1'b0;
        dr0 = n_drain_cyc;
        do_start(1, 2, 3);
        run_until_done(300, 1);
        step();
        total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL tmo_error got=%0d want=1", error); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL tmo_done got=%0d want=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL tmo_busy got=%0d want=0", busy); end
        total++; if (n_drain_cyc - dr0 !== 65) begin bad++; $display("[TB] FAIL tmo_drain_cycles got=%0d want=65", n_drain_cyc - dr0); end
        // A restart from DONE clears the sticky flags.
        lo_enable = 1'b1;
        do_start(1, 1, 0);
        total++; if ({error, done, busy} !== 3'b001) begin bad++; $display("[TB] FAIL restart_flags got=%b want=001", {error, done, busy}); end
        run_until_done(200, 1);
        total++; if ({error, done} !== 2'b01) begin bad++; $display("[TB] FAIL restart_result got=%b want=01", {error, done}); end
    endtask

    task automatic test_reset_mid_scatter();
        int ls0, k;
        upd_levels = 100; upd_from = 0;
        ls0 = n_level_start;
        do_start(1, 3, 5);
        src_valid = 1'b1;
        k = 0;
        while ((n_level_start - ls0 < 2) && (k < 200)) begin
            step();
            k++;
        end
        total++; if (n_level_start - ls0 !== 2) begin bad++; $display("[TB] FAIL mid_reach_level1 got=%0d want=2", n_level_start - ls0); end
        // A start while busy must not restart the run.
        do_start(7, 7, 0);
        total++; if ({pipe_control, src_ready, level_start} !== 4'b1010) begin bad++; $display("[TB] FAIL busy_start_ignored got=%b want=1010", {pipe_control, src_ready, level_start}); end
        total++; if (current_level !== 8'd1) begin bad++; $display("[TB] FAIL busy_start_level got=%0d want=1", current_level); end
        rst = 1'b1;
        step();
        total++; if ({pipe_control, src_ready, pipe_word_valid, pipe_last_input, level_start} !== 6'b0) begin bad++; $display("[TB] FAIL mid_reset_handshake got=%b want=000000", {pipe_control, src_ready, pipe_word_valid, pipe_last_input, level_start}); end
        total++; if ({busy, done, error} !== 3'b0) begin bad++; $display("[TB] FAIL mid_reset_status got=%b want=000", {busy, done, error}); end
        total++; if ((current_level !== 8'd0) || (level_updates !== 32'd0)) begin bad++; $display("[TB] FAIL mid_reset_counters got=%0d/%0d want=0/0", current_level, level_updates); end
        rst = 1'b0; src_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_gapped();
        test_max_level();
        test_zero_words();
        test_timeout();
        test_reset_mid_scatter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
